lsu_ctrl: RTL

Load/store controller between the core's execute stage and the byte-addressed data memory's second read port and its write port. Accepts one RISC-V load/store per handshake and performs aligned word reads. Sub-word stores are done as read-modify-write, because the memory only writes full 32-bit words. Returns load data, sign- or zero-extended, and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: controller state encoding, RV32I load/store funct3 codes and the
// alignment/legality rule shared by the load/store controller.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        SETTLE,
        ERR,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // True for a misaligned access or a funct3 that names no RV32I load/store.
    function automatic logic is_bad_access(input logic       we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] off);
        logic bad;
        bad = 1'b1;
        if (we) begin
            case (funct3)
                F3_SB:   bad = 1'b0;
                F3_SH:   bad = off[0];
                F3_SW:   bad = (off != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = off[0];
                F3_LW:         bad = (off != 2'b00);
                default:       bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte/half extract with sign/zero extension for loads,
// and byte/half merge into a read word for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_sh  = {off, 3'b000};
    assign half_sh  = {off[1], 4'b0000};
    assign byte_val = word[byte_sh +: 8];
    assign half_val = word[half_sh +: 16];

    // funct3[1:0] is the access size for both loads and stores; funct3[2] selects zero-extension.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        load_data = word;
        merged    = wdata;
        case (funct3[1:0])
            2'b00: begin
                load_data = funct3[2] ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
                merged                = word;
                merged[byte_sh +: 8]  = wdata[7:0];
            end
            2'b01: begin
                load_data = funct3[2] ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
                merged                = word;
                merged[half_sh +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32 load/store controller; aligned word reads, read-modify-write sub-word stores.
// Define LSU_BOUNDS_CHECK_EN to reject accesses whose word lies beyond MEM_SIZE.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_r_addr,
    input  logic [31:0] mem_r_data,
    output logic        mem_w_enable,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data
);

    if (MEM_SIZE < 4 || (MEM_SIZE % 4) != 0) begin : g_bad_mem_size
        $error("lsu_ctrl: MEM_SIZE must be a positive multiple of 4");
    end

    lsu_state_e  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        resp_valid_d, resp_err_d, mem_w_enable_d;
    logic [31:0] resp_rdata_d, mem_r_addr_d, mem_w_addr_d, mem_w_data_d;

    logic [31:0] req_waddr;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_waddr = {req_addr[31:2], 2'b00};

`ifdef LSU_BOUNDS_CHECK_EN
    assign out_of_range = ({1'b0, req_waddr} + 33'd3) >= 33'(MEM_SIZE);
`else
    assign out_of_range = 1'b0;
`endif

    assign req_err   = out_of_range || is_bad_access(req_we, req_funct3, req_addr[1:0]);
    assign req_ready = (state_q == IDLE);

    lsu_align u_align (
        .word      (mem_r_data),
        .off       (addr_q[1:0]),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata;
        mem_r_addr_d = mem_r_addr;
        mem_w_addr_d = mem_w_addr;
        mem_w_data_d = mem_w_data;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d     = req_funct3;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    resp_rdata_d = '0;
                    if (req_err) begin
                        state_d = ERR;
                    end else if (!req_we) begin
                        state_d      = LOAD;
                        mem_r_addr_d = req_waddr;
                    end else if (req_funct3 == F3_SW) begin
                        state_d      = WRITE;
                        mem_w_addr_d = req_waddr;
                        mem_w_data_d = req_wdata;
                    end else begin
                        state_d      = RMW_RD;
                        mem_r_addr_d = req_waddr;
                    end
                end
            end
            LOAD: begin
                state_d      = RESP;
                resp_rdata_d = load_data;
            end
            RMW_RD: begin
                state_d      = WRITE;
                mem_w_addr_d = {addr_q[31:2], 2'b00};
                mem_w_data_d = merged;
            end
            WRITE:  state_d = SETTLE;
            SETTLE: state_d = RESP;
            ERR:    state_d = RESP;
            RESP:   if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        resp_valid_d   = (state_d == RESP);
        mem_w_enable_d = (state_d == WRITE);
        resp_err_d     = (state_d == ERR) || ((state_d == RESP) && resp_err);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            mem_r_addr   <= '0;
            mem_w_enable <= 1'b0;
            mem_w_addr   <= '0;
            mem_w_data   <= '0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid   <= resp_valid_d;
            resp_err     <= resp_err_d;
            resp_rdata   <= resp_rdata_d;
            mem_r_addr   <= mem_r_addr_d;
            mem_w_enable <= mem_w_enable_d;
            mem_w_addr   <= mem_w_addr_d;
            mem_w_data   <= mem_w_data_d;
        end
    end

endmodule
